rx_pipe_arbiter: RTL and testbench
==================================

Name: rx_pipe_arbiter

Overview:
- Shares one downstream AHIR write pipe between two rx_fifo instances (two MAC receive ports).
- Grants are frame-atomic: once a source wins, it keeps the pipe until a word with the last bit (bit D-1) transfers.
- Round-robin between sources.
- Includes an overlong-frame watchdog so a stuck source cannot hold the pipe.

Parameters:
- D, 37, word width {last, data[31:0], keep[3:0]}; bit D-1 is the last flag.
- MAX_WORDS, 400, maximum words per frame before forced release.
- CW, 9, counter width; must satisfy 2^CW > MAX_WORDS.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- s0_write_data  in  D  source 0 word.
- s0_write_req  in  1  source 0 has a word.
- s0_write_ack  out  1  source 0 word accepted.
- s1_write_data  in  D  source 1 word.
- s1_write_req  in  1  source 1 has a word.
- s1_write_ack  out  1  source 1 word accepted.
- pipe_write_data  out  D  muxed word to the pipe.
- pipe_write_req  out  1  word valid toward the pipe.
- pipe_write_ack  in  1  pipe accepts the word.
- pipe_src_id  out  1  source of the current word.
- err_overlong  out  1  one-cycle pulse on forced release.
- stat_frames0  out  16  frames forwarded from source 0 (optional feature).
- stat_frames1  out  16  frames forwarded from source 1 (optional feature).
- stat_bad  out  16  bad-frame markers forwarded (optional feature).

Behaviour:
- Transfer: a cycle where pipe_write_req and pipe_write_ack are both 1.
- Reset values: on resetn=0, asynchronously: state=ARB, rr_ptr=0, word_cnt=0, all outputs 0.
- Reset asserted mid-frame abandons the frame with no flush; the rx_fifo side re-presents its word after reset.
- FSM states: ARB, GNT0, GNT1.
  - ARB: all outputs deasserted.
    - Only one source's req=1: go to that source's GNT.
    - Both req=1: go to GNT[rr_ptr].
    - Neither req=1: stay in ARB.
    - Arbitration latency is 1 cycle; the decision is registered.
  - GNTx:
    - pipe_write_data = sx_write_data (combinational).
    - pipe_write_req = sx_write_req.
    - sx_write_ack = pipe_write_ack & sx_write_req.
    - pipe_src_id = x.
    - Non-granted ack = 0.
    - Zero-latency pass-through; no data register.
  - Each transfer increments word_cnt.
  - Transfer with bit D-1 = 1:
    - Next state ARB.
    - rr_ptr <= ~x.
    - word_cnt <= 0.
  - Transfer without last where word_cnt == MAX_WORDS-1:
    - Next state ARB.
    - err_overlong = 1 for one cycle.
    - rr_ptr <= ~x, word_cnt <= 0.
    - The remainder of that frame is forwarded later as a new grant; the downstream detects the fragment.
  - sx_write_req drop during GNTx (source empty mid-frame): hold the grant; do not count idle cycles.
- Counter saturates at 2^CW-1; saturation is unreachable with legal MAX_WORDS.
- Ack is never given to a source whose req=0.
- At most one transfer per cycle.

Optional Feature:
- Macro: RX_PIPE_ARBITER_STATS_EN.
- Defined:
  - stat_frames0/1 increment on each last-word transfer from that source.
  - stat_bad increments when the transferred last word equals BAD_FRAME_WORD ({1, 32'd1, 4'd0}).
  - All three are 16-bit wrapping counters, reset to 0.
- Undefined: ports remain present, tied to 0; no counter flops.

Decomposition:
- Package rx_mac_pkg holds:
  - D, BAD_FRAME_WORD, LAST_BIT = D-1.
  - State enum {ARB, GNT0, GNT1}.
  - Shared with rx_fifo.
- Sub-module rx_arb_stats (three counters, inputs: xfer, last, src, data) is instantiated only under the macro.

Test Plan:
- Only s0 requests; 3-word frame, last on word 3:
  - 1 ARB cycle, then 3 transfers with pipe_src_id=0.
  - Return to ARB; rr_ptr=1.
- Both request continuously, 2-word frames each:
  - Order s0,s0,s1,s1,s0,s0.
  - No interleaving within a frame; one ARB cycle between frames.
- Granted s1; pipe_write_ack held 0 for 5 cycles mid-frame while s0 requests:
  - s0_write_ack stays 0; s1 data held stable.
  - Grant persists until s1's last word transfers.
- s0 streams 400 words with no last:
  - err_overlong pulses once after word 400; state returns to ARB.
  - s1, if pending, is granted next.
- resetn pulled low during word 2 of a frame:
  - All outputs 0 in the same cycle.
  - After release, ARB with rr_ptr=0.
- With RX_PIPE_ARBITER_STATS_EN, s1 sends a good frame then BAD_FRAME_WORD (single-word frame):
  - stat_frames1=2, stat_bad=1, stat_frames0=0.

Source files
------------

// File: rtl/rx_mac_pkg.sv
// Definitions shared by the rx MAC receive path (rx_fifo, rx_pipe_arbiter):
// word layout, bad-frame marker and arbiter state encoding.
package rx_mac_pkg;

  localparam int D        = 37;
  localparam int LAST_BIT = D - 1;

  // Word layout is {last, data[31:0], keep[3:0]}.
  localparam logic [D-1:0] BAD_FRAME_WORD = {1'b1, 32'd1, 4'd0};

  typedef logic [1:0] state_t;
  localparam state_t ARB  = 2'd0;
  localparam state_t GNT0 = 2'd1;
  localparam state_t GNT1 = 2'd2;

endpackage

// File: rtl/rx_arb_stats.sv
// Frame statistics for rx_pipe_arbiter: frames per source and bad-frame markers.
// Instantiated only when RX_PIPE_ARBITER_STATS_EN is defined.
module rx_arb_stats
  import rx_mac_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         xfer,
  input  logic         last,
  input  logic         src,
  input  logic [D-1:0] data,
  output logic [15:0]  frames0,
  output logic [15:0]  frames1,
  output logic [15:0]  bad
);

  logic [15:0] frames0_q, frames1_q, bad_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frames0_q <= '0;
      frames1_q <= '0;
      bad_q     <= '0;
    end else if (xfer && last) begin
      if (src) frames1_q <= frames1_q + 16'd1;
      else     frames0_q <= frames0_q + 16'd1;
      if (data == BAD_FRAME_WORD) bad_q <= bad_q + 16'd1;
    end
  end

  assign frames0 = frames0_q;
  assign frames1 = frames1_q;
  assign bad     = bad_q;

endmodule

// File: rtl/rx_pipe_arbiter.sv
// Frame-atomic round-robin arbiter sharing one write pipe between two rx_fifos,
// with an overlong-frame watchdog. Statistics enabled by RX_PIPE_ARBITER_STATS_EN.
//
//   state | meaning
//   ARB   | no grant; registered round-robin decision between requesters
//   GNT0  | source 0 owns the pipe until its last word (or watchdog)
//   GNT1  | source 1 owns the pipe until its last word (or watchdog)
module rx_pipe_arbiter #(
  parameter int D         = 37,
  parameter int MAX_WORDS = 400,
  parameter int CW        = 9
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [D-1:0] s0_write_data,
  input  logic         s0_write_req,
  output logic         s0_write_ack,
  input  logic [D-1:0] s1_write_data,
  input  logic         s1_write_req,
  output logic         s1_write_ack,
  output logic [D-1:0] pipe_write_data,
  output logic         pipe_write_req,
  input  logic         pipe_write_ack,
  output logic         pipe_src_id,
  output logic         err_overlong,
  output logic [15:0]  stat_frames0,
  output logic [15:0]  stat_frames1,
  output logic [15:0]  stat_bad
);
  import rx_mac_pkg::*;

  state_t        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          err_q, err_d;
  logic          xfer;
  logic          is_last;
  logic          gnt_src;

  // Pure pass-through in grant states; everything is quiet in ARB and reset.
  always_comb begin
    pipe_write_data = '0;
    pipe_write_req  = 1'b0;
    pipe_src_id     = 1'b0;
    s0_write_ack    = 1'b0;
    s1_write_ack    = 1'b0;
    case (state_q)
      GNT0: begin
        pipe_write_data = s0_write_data;
        pipe_write_req  = s0_write_req;
        s0_write_ack    = pipe_write_ack & s0_write_req;
      end
      GNT1: begin
        pipe_write_data = s1_write_data;
        pipe_write_req  = s1_write_req;
        pipe_src_id     = 1'b1;
        s1_write_ack    = pipe_write_ack & s1_write_req;
      end
      default: ;
    endcase
  end

  assign gnt_src = (state_q == GNT1);
  assign xfer    = pipe_write_req & pipe_write_ack;
  assign is_last = pipe_write_data[D-1];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      ARB: begin
        if (s0_write_req && s1_write_req) state_d = rr_ptr_q ? GNT1 : GNT0;
        else if (s0_write_req)            state_d = GNT0;
        else if (s1_write_req)            state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (xfer) begin
          // The watchdog trips on the MAX_WORDS-th word if it is not a last word.
          if (is_last || word_cnt_q == CW'(MAX_WORDS - 1)) begin
            state_d    = ARB;
            rr_ptr_d   = ~gnt_src;
            word_cnt_d = '0;
            err_d      = ~is_last;
          end else if (word_cnt_q != '1) begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ARB;
      rr_ptr_q   <= 1'b0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_overlong = err_q;

`ifdef RX_PIPE_ARBITER_STATS_EN
  rx_arb_stats u_stats (
    .clk     (clk),
    .resetn  (resetn),
    .xfer    (xfer),
    .last    (is_last),
    .src     (gnt_src),
    .data    (pipe_write_data),
    .frames0 (stat_frames0),
    .frames1 (stat_frames1),
    .bad     (stat_bad)
  );
`else
  assign stat_frames0 = 16'd0;
  assign stat_frames1 = 16'd0;
  assign stat_bad     = 16'd0;
`endif

endmodule

// File: tb/tb_rx_pipe_arbiter.sv
// Directed self-checking bench for rx_pipe_arbiter.
module tb_rx_pipe_arbiter;

  localparam int D = 37;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [D-1:0] s0_write_data = '0;
  logic         s0_write_req = 1'b0;
  logic         s0_write_ack;
  logic [D-1:0] s1_write_data = '0;
  logic         s1_write_req = 1'b0;
  logic         s1_write_ack;
  logic [D-1:0] pipe_write_data;
  logic         pipe_write_req;
  logic         pipe_write_ack = 1'b0;
  logic         pipe_src_id;
  logic         err_overlong;
  logic [15:0]  stat_frames0, stat_frames1, stat_bad;

  int checks = 0;
  int errors = 0;

  logic [D-1:0] q0[$];
  logic [D-1:0] q1[$];

  logic         obs_req, obs_src, obs_ack0, obs_ack1, obs_err;
  logic [D-1:0] obs_data;

  logic [D-1:0] log_data[$];
  logic         log_src[$];
  int           log_cyc[$];

  rx_pipe_arbiter dut (
    .clk             (clk),
    .resetn          (resetn),
    .s0_write_data   (s0_write_data),
    .s0_write_req    (s0_write_req),
    .s0_write_ack    (s0_write_ack),
    .s1_write_data   (s1_write_data),
    .s1_write_req    (s1_write_req),
    .s1_write_ack    (s1_write_ack),
    .pipe_write_data (pipe_write_data),
    .pipe_write_req  (pipe_write_req),
    .pipe_write_ack  (pipe_write_ack),
    .pipe_src_id     (pipe_src_id),
    .err_overlong    (err_overlong),
    .stat_frames0    (stat_frames0),
    .stat_frames1    (stat_frames1),
    .stat_bad        (stat_bad)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] mk(input logic last, input logic [31:0] val);
    return {last, val, 4'hF};
  endfunction

  task automatic drive_srcs();
    s0_write_req  = (q0.size() > 0);
    s0_write_data = (q0.size() > 0) ? q0[0] : '0;
    s1_write_req  = (q1.size() > 0);
    s1_write_data = (q1.size() > 0) ? q1[0] : '0;
  endtask

  // One clock: observe at negedge, then sources retire acked words after the edge.
  task automatic run_cycle();
    @(negedge clk);
    obs_req  = pipe_write_req;
    obs_src  = pipe_src_id;
    obs_data = pipe_write_data;
    obs_ack0 = s0_write_ack;
    obs_ack1 = s1_write_ack;
    obs_err  = err_overlong;
    @(posedge clk);
    #1;
    if (obs_ack0) void'(q0.pop_front());
    if (obs_ack1) void'(q1.pop_front());
    drive_srcs();
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    q0.delete();
    q1.delete();
    log_data.delete();
    log_src.delete();
    log_cyc.delete();
    drive_srcs();
    pipe_write_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    s0_write_req   = 1'b1;
    s0_write_data  = mk(1'b0, 32'h1234);
    pipe_write_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (pipe_write_req !== 1'b0 || pipe_write_data !== '0 || s0_write_ack !== 1'b0 ||
        s1_write_ack !== 1'b0 || pipe_src_id !== 1'b0 || err_overlong !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b data=%h ack0=%b ack1=%b src=%b err=%b required all 0",
               pipe_write_req, pipe_write_data, s0_write_ack, s1_write_ack, pipe_src_id, err_overlong);
    end
    checks++;
    if (stat_frames0 !== 16'd0 || stat_frames1 !== 16'd0 || stat_bad !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats: %0d %0d %0d required 0 0 0", stat_frames0, stat_frames1, stat_bad);
    end
  endtask

  task automatic test_single_s0();
    logic [D-1:0] w[3];
    apply_reset();
    w[0] = mk(1'b0, 32'hA0);
    w[1] = mk(1'b0, 32'hA1);
    w[2] = mk(1'b1, 32'hA2);
    for (int i = 0; i < 3; i++) q0.push_back(w[i]);
    drive_srcs();
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      if (c == 0 || c == 4) begin
        checks++;
        if (obs_req !== 1'b0) begin
          errors++;
          $display("FAIL single_arb_c%0d: pipe_req=%b required 0", c, obs_req);
        end
      end else begin
        checks++;
        if (obs_req !== 1'b1 || obs_src !== 1'b0 || obs_data !== w[c-1] || obs_ack0 !== 1'b1) begin
          errors++;
          $display("FAIL single_xfer_c%0d: req=%b src=%b data=%h ack0=%b required 1 0 %h 1",
                   c, obs_req, obs_src, obs_data, obs_ack0, w[c-1]);
        end
      end
    end
    checks++;
    if (dut.rr_ptr_q !== 1'b1) begin
      errors++;
      $display("FAIL single_rr_ptr: got %b required 1", dut.rr_ptr_q);
    end
  endtask

  task automatic test_round_robin();
    logic [D-1:0] exp_data[6];
    logic         exp_src[6];
    int           exp_cyc[6];
    apply_reset();
    exp_data = '{mk(1'b0, 32'hA0), mk(1'b1, 32'hA1), mk(1'b0, 32'hB0),
                 mk(1'b1, 32'hB1), mk(1'b0, 32'hA2), mk(1'b1, 32'hA3)};
    exp_src  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_cyc  = '{1, 2, 4, 5, 7, 8};
    q0.push_back(exp_data[0]); q0.push_back(exp_data[1]);
    q0.push_back(exp_data[4]); q0.push_back(exp_data[5]);
    q1.push_back(exp_data[2]); q1.push_back(exp_data[3]);
    drive_srcs();
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      if (obs_req && pipe_write_ack) begin
        log_data.push_back(obs_data);
        log_src.push_back(obs_src);
        log_cyc.push_back(c);
      end
    end
    checks++;
    if (log_data.size() != 6) begin
      errors++;
      $display("FAIL rr_count: got %0d transfers required 6", log_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (log_data[i] !== exp_data[i] || log_src[i] !== exp_src[i] || log_cyc[i] != exp_cyc[i]) begin
          errors++;
          $display("FAIL rr_xfer%0d: data=%h src=%b cyc=%0d required %h %b %0d",
                   i, log_data[i], log_src[i], log_cyc[i], exp_data[i], exp_src[i], exp_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [D-1:0] b[3];
    logic [D-1:0] a0;
    apply_reset();
    b[0] = mk(1'b0, 32'hB0);
    b[1] = mk(1'b0, 32'hB1);
    b[2] = mk(1'b1, 32'hB2);
    a0   = mk(1'b1, 32'hA0);
    for (int i = 0; i < 3; i++) q1.push_back(b[i]);
    drive_srcs();
    run_cycle();
    q0.push_back(a0);
    drive_srcs();
    run_cycle();
    checks++;
    if (obs_src !== 1'b1 || obs_data !== b[0] || obs_ack1 !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: src=%b data=%h ack1=%b required 1 %h 1", obs_src, obs_data, obs_ack1, b[0]);
    end
    pipe_write_ack = 1'b0;
    for (int c = 2; c < 7; c++) begin
      run_cycle();
      checks++;
      if (obs_req !== 1'b1 || obs_src !== 1'b1 || obs_data !== b[1] || obs_ack0 !== 1'b0 || obs_ack1 !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_c%0d: req=%b src=%b data=%h ack0=%b ack1=%b required 1 1 %h 0 0",
                 c, obs_req, obs_src, obs_data, obs_ack0, obs_ack1, b[1]);
      end
    end
    pipe_write_ack = 1'b1;
    for (int c = 7; c < 9; c++) begin
      run_cycle();
      checks++;
      if (obs_src !== 1'b1 || obs_data !== b[c-6] || obs_ack1 !== 1'b1 || obs_ack0 !== 1'b0) begin
        errors++;
        $display("FAIL bp_resume_c%0d: src=%b data=%h ack1=%b ack0=%b required 1 %h 1 0",
                 c, obs_src, obs_data, obs_ack1, obs_ack0, b[c-6]);
      end
    end
    run_cycle();
    checks++;
    if (obs_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_arb: pipe_req=%b required 0", obs_req);
    end
    run_cycle();
    checks++;
    if (obs_src !== 1'b0 || obs_data !== a0 || obs_ack0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_s0_next: src=%b data=%h ack0=%b required 0 %h 1", obs_src, obs_data, obs_ack0, a0);
    end
  endtask

  task automatic test_overlong();
    int err_cnt = 0;
    int err_cyc = -1;
    int s1_early = 0;
    logic req_401 = 1'b1;
    apply_reset();
    for (int i = 0; i <= 400; i++) q0.push_back(mk(i == 400, 32'(i)));
    q1.push_back(mk(1'b1, 32'hB0));
    drive_srcs();
    for (int c = 0; c < 410; c++) begin
      run_cycle();
      if (obs_err) begin
        err_cnt++;
        err_cyc = c;
      end
      if (c == 401) req_401 = obs_req;
      if (obs_req && pipe_write_ack) begin
        log_data.push_back(obs_data);
        log_src.push_back(obs_src);
        log_cyc.push_back(c);
      end
    end
    checks++;
    if (err_cnt != 1 || err_cyc != 401) begin
      errors++;
      $display("FAIL overlong_err: pulses=%0d at cyc %0d required 1 at 401", err_cnt, err_cyc);
    end
    checks++;
    if (req_401 !== 1'b0) begin
      errors++;
      $display("FAIL overlong_arb: pipe_req at cyc 401=%b required 0", req_401);
    end
    checks++;
    if (log_data.size() != 402) begin
      errors++;
      $display("FAIL overlong_count: got %0d transfers required 402", log_data.size());
    end else begin
      for (int i = 0; i < 400; i++) if (log_src[i] !== 1'b0) s1_early++;
      checks++;
      if (s1_early != 0 || log_cyc[399] != 400) begin
        errors++;
        $display("FAIL overlong_s0_run: s1 words=%0d last s0 cyc=%0d required 0 400", s1_early, log_cyc[399]);
      end
      checks++;
      if (log_src[400] !== 1'b1 || log_cyc[400] != 402) begin
        errors++;
        $display("FAIL overlong_s1_next: src=%b cyc=%0d required 1 402", log_src[400], log_cyc[400]);
      end
      checks++;
      if (log_src[401] !== 1'b0 || log_cyc[401] != 404 || log_data[401] !== mk(1'b1, 32'd400)) begin
        errors++;
        $display("FAIL overlong_fragment: src=%b cyc=%0d data=%h required 0 404 %h",
                 log_src[401], log_cyc[401], log_data[401], mk(1'b1, 32'd400));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [D-1:0] w[3];
    apply_reset();
    w[0] = mk(1'b0, 32'hC0);
    w[1] = mk(1'b0, 32'hC1);
    w[2] = mk(1'b1, 32'hC2);
    for (int i = 0; i < 3; i++) q0.push_back(w[i]);
    drive_srcs();
    run_cycle();
    run_cycle();
    @(negedge clk);
    checks++;
    if (pipe_write_req !== 1'b1 || pipe_write_data !== w[1]) begin
      errors++;
      $display("FAIL midrst_word2: req=%b data=%h required 1 %h", pipe_write_req, pipe_write_data, w[1]);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (pipe_write_req !== 1'b0 || pipe_write_data !== '0 || s0_write_ack !== 1'b0 || pipe_src_id !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: req=%b data=%h ack0=%b src=%b required all 0",
               pipe_write_req, pipe_write_data, s0_write_ack, pipe_src_id);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    checks++;
    if (dut.rr_ptr_q !== 1'b0 || dut.word_cnt_q !== '0) begin
      errors++;
      $display("FAIL midrst_regs: rr_ptr=%b word_cnt=%0d required 0 0", dut.rr_ptr_q, dut.word_cnt_q);
    end
    @(negedge clk);
    checks++;
    if (pipe_write_req !== 1'b0) begin
      errors++;
      $display("FAIL midrst_arb: pipe_req=%b required 0", pipe_write_req);
    end
    run_cycle();
    checks++;
    if (obs_src !== 1'b0 || obs_data !== w[1] || obs_ack0 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_represent: src=%b data=%h ack0=%b required 0 %h 1", obs_src, obs_data, obs_ack0, w[1]);
    end
  endtask

  task automatic test_stats();
    logic [D-1:0] bad_word;
    bad_word = {1'b1, 32'd1, 4'd0};
    apply_reset();
    q1.push_back(mk(1'b0, 32'hB0));
    q1.push_back(mk(1'b1, 32'hB1));
    q1.push_back(bad_word);
    drive_srcs();
    for (int c = 0; c < 8; c++) run_cycle();
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL stats_drain: %0d words left required 0", q1.size());
    end
`ifdef RX_PIPE_ARBITER_STATS_EN
    checks++;
    if (stat_frames1 !== 16'd2 || stat_bad !== 16'd1 || stat_frames0 !== 16'd0) begin
      errors++;
      $display("FAIL stats_counts: f1=%0d bad=%0d f0=%0d required 2 1 0", stat_frames1, stat_bad, stat_frames0);
    end
`else
    checks++;
    if (stat_frames1 !== 16'd0 || stat_bad !== 16'd0 || stat_frames0 !== 16'd0) begin
      errors++;
      $display("FAIL stats_tied: f1=%0d bad=%0d f0=%0d required 0 0 0", stat_frames1, stat_bad, stat_frames0);
    end
`endif
  endtask

  initial begin
    #12;
    test_reset();
    test_single_s0();
    test_round_robin();
    test_backpressure();
    test_overlong();
    test_reset_midframe();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
